// File: rtl/mem_ctrl.sv
// mem_ctrl: memory controller between the pipeline and the byte-wide unified
// RAM/IO bus. Arbitrates IF fetches against MEM-stage loads/stores (store wins
// over load, load wins over fetch), serialises each 1/2/4-byte access into
// per-byte bus cycles and returns the assembled little-endian word.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               0 freezes every register and forces mem_wr low
//   if_req_in/if_addr_in fetch request (held until if_done_out) and address
//   inst_out/if_done_out fetched word and its one-cycle completion pulse
//   read_req_in/write_req_in/mem_addr_in/mem_val_in/store_len_in
//                        MEM-stage load/store request, address, data, size
//   mem_val_read_out/mem_done_out  load word and one-cycle completion pulse
//   memctrl_busy_out     00 idle, 01 fetch, 10 MEM read, 11 MEM write
//   mem_din/mem_dout/mem_a/mem_wr  byte-wide RAM bus (read data arrives one
//                        cycle after its address)
//
// Build option: MEMCTRL_IO_STALL_EN adds io_buffer_full_in; a write to the IO
// window (mem_a[17:16]==2'b11) waits while the IO buffer reports full.

module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [31:0]       inst_out,
  output logic              if_done_out,
  input  logic              read_req_in,
  input  logic              write_req_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [31:0]       mem_val_in,
  input  logic [2:0]        store_len_in,
  output logic [31:0]       mem_val_read_out,
  output logic              mem_done_out,
  output logic [1:0]        memctrl_busy_out,
`ifdef MEMCTRL_IO_STALL_EN
  input  logic              io_buffer_full_in,
`endif
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_RD  = 2'b01,
    MEM_RD = 2'b10,
    MEM_WR = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        len, len_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [31:0]       wval, wval_n;
  logic [23:0]       rbuf, rbuf_n;
  logic [31:0]       inst_q, inst_n;
  logic [31:0]       mem_val_q, mem_val_n;
  logic              if_done_q, if_done_n;
  logic              mem_done_q, mem_done_n;

  logic [ADDR_W-1:0] byte_addr;
  logic [ADDR_W-1:0] a_c;
  logic [7:0]        dout_c;
  logic              wr_c;
  logic              stall;

  // Current byte address; natural modulo-2^ADDR_W wrap.
  assign byte_addr = addr + {{(ADDR_W-3){1'b0}}, cnt};

`ifdef MEMCTRL_IO_STALL_EN
  assign stall = (state == MEM_WR) && (byte_addr[17:16] == 2'b11) && io_buffer_full_in;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      cnt        <= '0;
      len        <= '0;
      addr       <= '0;
      wval       <= '0;
      rbuf       <= '0;
      inst_q     <= '0;
      mem_val_q  <= '0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else if (rdy_in) begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      addr       <= addr_n;
      wval       <= wval_n;
      rbuf       <= rbuf_n;
      inst_q     <= inst_n;
      mem_val_q  <= mem_val_n;
      if_done_q  <= if_done_n;
      mem_done_q <= mem_done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len;
    addr_n     = addr;
    wval_n     = wval;
    rbuf_n     = rbuf;
    inst_n     = inst_q;
    mem_val_n  = mem_val_q;
    if_done_n  = 1'b0;
    mem_done_n = 1'b0;
    a_c        = '0;
    dout_c     = 8'h00;
    wr_c       = 1'b0;

    case (state)
      IDLE: begin
        // The requester still holds its line during the done cycle, so
        // sampling is suppressed then to avoid serving it twice.
        if (!if_done_q && !mem_done_q) begin
          if (write_req_in) begin
            state_n = MEM_WR;
            addr_n  = mem_addr_in;
            wval_n  = mem_val_in;
            len_n   = store_len_in + 3'd1;
            cnt_n   = 3'd0;
          end else if (read_req_in) begin
            state_n = MEM_RD;
            addr_n  = mem_addr_in;
            len_n   = 3'd4;
            cnt_n   = 3'd0;
          end else if (if_req_in) begin
            state_n = IF_RD;
            addr_n  = if_addr_in;
            len_n   = 3'd4;
            cnt_n   = 3'd0;
          end
        end
      end

      IF_RD, MEM_RD: begin
        if (cnt < len) begin
          a_c = byte_addr;
        end
        // RAM data lags the address by one cycle, so byte cnt-1 arrives now.
        case (cnt)
          3'd1:    rbuf_n[7:0]   = mem_din;
          3'd2:    rbuf_n[15:8]  = mem_din;
          3'd3:    rbuf_n[23:16] = mem_din;
          default: ;
        endcase
        if (cnt == len) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          if (state == IF_RD) begin
            inst_n    = {mem_din, rbuf};
            if_done_n = 1'b1;
          end else begin
            mem_val_n  = {mem_din, rbuf};
            mem_done_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end

      MEM_WR: begin
        a_c = byte_addr;
        case (cnt[1:0])
          2'd0:    dout_c = wval[7:0];
          2'd1:    dout_c = wval[15:8];
          2'd2:    dout_c = wval[23:16];
          default: dout_c = wval[31:24];
        endcase
        wr_c = !stall;
        if (!stall) begin
          if (cnt == len - 3'd1) begin
            state_n    = IDLE;
            cnt_n      = 3'd0;
            mem_done_n = 1'b1;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign mem_a            = a_c;
  assign mem_dout         = dout_c;
  assign mem_wr           = wr_c & rdy_in;
  assign memctrl_busy_out = state;
  assign inst_out         = inst_q;
  assign if_done_out      = if_done_q;
  assign mem_val_read_out = mem_val_q;
  assign mem_done_out     = mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl with a byte-wide RAM model,
// a shadow memory for expected data and scoreboard queues for fetch, MEM
// completions and individual bus write cycles.
// Build option: MEMCTRL_IO_STALL_EN enables the IO stall scenario.

module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_addr_in;
  logic [31:0] inst_out;
  logic        if_done_out;
  logic        read_req_in;
  logic        write_req_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_val_in;
  logic [2:0]  store_len_in;
  logic [31:0] mem_val_read_out;
  logic        mem_done_out;
  logic [1:0]  memctrl_busy_out;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
`ifdef MEMCTRL_IO_STALL_EN
  logic        io_buffer_full_in;
`endif

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .if_req_in        (if_req_in),
    .if_addr_in       (if_addr_in),
    .inst_out         (inst_out),
    .if_done_out      (if_done_out),
    .read_req_in      (read_req_in),
    .write_req_in     (write_req_in),
    .mem_addr_in      (mem_addr_in),
    .mem_val_in       (mem_val_in),
    .store_len_in     (store_len_in),
    .mem_val_read_out (mem_val_read_out),
    .mem_done_out     (mem_done_out),
    .memctrl_busy_out (memctrl_busy_out),
`ifdef MEMCTRL_IO_STALL_EN
    .io_buffer_full_in(io_buffer_full_in),
`endif
    .mem_din          (mem_din),
    .mem_dout         (mem_dout),
    .mem_a            (mem_a),
    .mem_wr           (mem_wr)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] cyc;
    logic        chk;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t if_q[$];
  exp_t mem_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  bit         loaded = 1'b0;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      4:       return 8'h13;
      5:       return 8'h05;
      6:       return 8'h10;
      7:       return 8'h00;
      default: return 8'(i * 7 + 3);
    endcase
  endfunction

  // RAM model: one-cycle read latency, write on mem_wr.
  always @(posedge clk_in) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
      loaded <= 1'b1;
    end else begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: completions and bus writes popped as they appear.
  always @(negedge clk_in) begin
    if (if_done_out) begin
      if (if_q.size() == 0) checkOutput("if_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = if_q.pop_front();
        checkOutput("if_data", inst_out, e.data);
        checkOutput("if_cycle", cyc, e.cyc);
      end
    end
    if (mem_done_out) begin
      if (mem_q.size() == 0) checkOutput("mem_unexpected", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = mem_q.pop_front();
        if (e.chk) checkOutput("mem_data", mem_val_read_out, e.data);
        checkOutput("mem_cycle", cyc, e.cyc);
      end
    end
    if (mem_wr) begin
      if (wr_q.size() == 0) checkOutput("wr_unexpected", 32'd1, 32'd0);
      else begin
        wr_t w;
        w = wr_q.pop_front();
        checkOutput("wr_addr", mem_a, w.addr);
        checkOutput("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk_in);
    #1;
  endtask

  // Raise a request in the current cycle and push the expected outcome.
  // kind: 0 fetch, 1 load, 2 store. extra adds cycles spent waiting.
  task automatic applyStimulus(input int kind, input logic [31:0] addr,
                               input logic [31:0] val, input logic [2:0] len,
                               input int extra);
    exp_t e;
    e.chk = 1'b1;
    if (kind == 2) begin
      write_req_in = 1'b1;
      mem_addr_in  = addr;
      mem_val_in   = val;
      store_len_in = len;
      for (int i = 0; i <= int'(len); i++) begin
        wr_t w;
        logic [31:0] a;
        a      = addr + 32'(i);
        w.addr = a;
        w.data = val[8*i +: 8];
        wr_q.push_back(w);
        shadow[a[15:0]] = w.data;
      end
      e.data = 32'd0;
      e.chk  = 1'b0;
      e.cyc  = 32'(cyc + int'(len) + 2 + extra);
      mem_q.push_back(e);
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] a;
        a = addr + 32'(i);
        e.data[8*i +: 8] = shadow[a[15:0]];
      end
      e.cyc = 32'(cyc + 6 + extra);
      if (kind == 0) begin
        if_req_in  = 1'b1;
        if_addr_in = addr;
        if_q.push_back(e);
      end else begin
        read_req_in = 1'b1;
        mem_addr_in = addr;
        mem_q.push_back(e);
      end
    end
  endtask

  task automatic waitDone(input int kind);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk_in);
      if (kind == 0 ? if_done_out : mem_done_out) seen = 1'b1;
    end
    if (!seen) checkOutput("timeout", 32'd0, 32'd1);
    nextCycle();
    case (kind)
      0:       if_req_in    = 1'b0;
      1:       read_req_in  = 1'b0;
      default: write_req_in = 1'b0;
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = init_byte(i);
    rst_in       = 1'b1;
    rdy_in       = 1'b1;
    if_req_in    = 1'b0;
    if_addr_in   = 32'd0;
    read_req_in  = 1'b0;
    write_req_in = 1'b0;
    mem_addr_in  = 32'd0;
    mem_val_in   = 32'd0;
    store_len_in = 3'd0;
`ifdef MEMCTRL_IO_STALL_EN
    io_buffer_full_in = 1'b0;
`endif

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    checkOutput("rst_busy", {30'd0, memctrl_busy_out}, 32'd0);
    checkOutput("rst_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rst_a", mem_a, 32'd0);
    checkOutput("rst_inst", inst_out, 32'd0);
    checkOutput("rst_done", {30'd0, if_done_out, mem_done_out}, 32'd0);
    nextCycle();
    rst_in = 1'b0;
    nextCycle();

    $display("[TB] fetch 0x4");
    applyStimulus(0, 32'h4, 32'd0, 3'd0, 0);
    @(negedge clk_in);
    checkOutput("busy_c0", {30'd0, memctrl_busy_out}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      checkOutput("busy_fetch", {30'd0, memctrl_busy_out}, 32'd1);
    end
    waitDone(0);
    checkOutput("inst_value", inst_out, 32'h0010_0513);

    $display("[TB] SB 0xAB at 0x1003");
    applyStimulus(2, 32'h1003, 32'h0000_00AB, 3'd0, 0);
    waitDone(2);

    $display("[TB] SW then LW 0x100");
    applyStimulus(2, 32'h100, 32'hDEAD_BEEF, 3'd3, 0);
    waitDone(2);
    applyStimulus(1, 32'h100, 32'd0, 3'd0, 0);
    waitDone(1);

    $display("[TB] SH then LW 0x400");
    applyStimulus(2, 32'h402, 32'h0000_9876, 3'd1, 0);
    waitDone(2);
    applyStimulus(1, 32'h400, 32'd0, 3'd0, 0);
    waitDone(1);

    // Load wins; fetch is sampled the cycle after mem_done drops.
    $display("[TB] fetch and load together");
    applyStimulus(1, 32'h100, 32'd0, 3'd0, 0);
    applyStimulus(0, 32'h4, 32'd0, 3'd0, 7);
    waitDone(1);
    waitDone(0);

    $display("[TB] load arrives during fetch");
    applyStimulus(0, 32'h4, 32'd0, 3'd0, 0);
    nextCycle();
    nextCycle();
    applyStimulus(1, 32'h400, 32'd0, 3'd0, 5);
    waitDone(0);
    waitDone(1);

    $display("[TB] store and fetch together");
    applyStimulus(2, 32'h500, 32'h0000_0077, 3'd0, 0);
    applyStimulus(0, 32'h4, 32'd0, 3'd0, 3);
    waitDone(2);
    waitDone(0);

    $display("[TB] address wrap");
    applyStimulus(2, 32'hFFFF_FFFE, 32'h0BAD_F00D, 3'd3, 0);
    waitDone(2);
    applyStimulus(1, 32'hFFFF_FFFE, 32'd0, 3'd0, 0);
    waitDone(1);

    $display("[TB] rdy low during SW");
    applyStimulus(2, 32'h300, 32'hCAFE_F00D, 3'd3, 2);
    nextCycle();
    nextCycle();
    rdy_in = 1'b0;
    @(negedge clk_in);
    checkOutput("rdy_wr0", {31'd0, mem_wr}, 32'd0);
    nextCycle();
    @(negedge clk_in);
    checkOutput("rdy_wr1", {31'd0, mem_wr}, 32'd0);
    nextCycle();
    rdy_in = 1'b1;
    waitDone(2);

    // Only bytes 0 and 1 reach RAM before the reset edge.
    $display("[TB] reset mid-SW");
    write_req_in = 1'b1;
    mem_addr_in  = 32'h200;
    mem_val_in   = 32'h1122_3344;
    store_len_in = 3'd3;
    begin
      wr_t w;
      w.addr = 32'h200; w.data = 8'h44; wr_q.push_back(w); shadow[16'h200] = 8'h44;
      w.addr = 32'h201; w.data = 8'h33; wr_q.push_back(w); shadow[16'h201] = 8'h33;
    end
    nextCycle();
    nextCycle();
    rst_in       = 1'b1;
    write_req_in = 1'b0;
    nextCycle();
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("rstmid_wr", {31'd0, mem_wr}, 32'd0);
    checkOutput("rstmid_busy", {30'd0, memctrl_busy_out}, 32'd0);
    checkOutput("rstmid_done", {31'd0, mem_done_out}, 32'd0);
    checkOutput("rstmid_val", mem_val_read_out, 32'd0);
    nextCycle();
    applyStimulus(1, 32'h200, 32'd0, 3'd0, 0);
    waitDone(1);

`ifdef MEMCTRL_IO_STALL_EN
    $display("[TB] IO stall SB 0x30000");
    io_buffer_full_in = 1'b1;
    applyStimulus(2, 32'h0003_0000, 32'h0000_005C, 3'd0, 3);
    for (int k = 1; k <= 3; k++) begin
      nextCycle();
      @(negedge clk_in);
      checkOutput("stall_wr", {31'd0, mem_wr}, 32'd0);
    end
    nextCycle();
    io_buffer_full_in = 1'b0;
    waitDone(2);
`endif

    repeat (4) nextCycle();
    checkOutput("ifq_left", if_q.size(), 32'd0);
    checkOutput("memq_left", mem_q.size(), 32'd0);
    checkOutput("wrq_left", wr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
